mips_multicycle_controller: RTL

Control unit for the multicycle MIPS datapath. It is the initiator of the ALU interface: it drives the 3-bit ALU function code `alucontrol` and consumes the ALU `zero` flag. It sequences each instruction through fetch, decode, execute, memory and writeback states, and drives every datapath enable and mux select. It sits between the instruction register (`op`, `funct` fields) and the datapath.

---
 rtl/mips_pkg.sv | 48 ++++
 rtl/alu_decoder.sv | 30 +++
 rtl/mips_multicycle_controller.sv | 167 ++++++++++++++++
 3 files changed

// File: rtl/mips_pkg.sv
// Shared ISA constants for the multicycle MIPS: opcodes, funct codes,
// ALU function codes and the controller state encoding.
package mips_pkg;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;

  localparam logic [5:0] FN_ADD = 6'b100000;
  localparam logic [5:0] FN_SUB = 6'b100010;
  localparam logic [5:0] FN_AND = 6'b100100;
  localparam logic [5:0] FN_OR  = 6'b100101;
  localparam logic [5:0] FN_SLT = 6'b101010;

  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_SUB = 3'b110;
  localparam logic [2:0] ALU_SLT = 3'b111;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  typedef enum logic [3:0] {
    S_FETCH,
    S_DECODE,
    S_MEMADR,
    S_MEMRD,
    S_MEMWB,
    S_MEMWR,
    S_RTYPEEX,
    S_RTYPEWB,
    S_BEQEX,
    S_ADDIEX,
    S_ADDIWB,
    S_JEX
  } state_t;

  function automatic logic funct_known(input logic [5:0] f);
    return (f == FN_ADD) || (f == FN_SUB) || (f == FN_AND) ||
           (f == FN_OR)  || (f == FN_SLT);
  endfunction

endpackage

// File: rtl/alu_decoder.sv
// Combinational ALU function decoder: fixed add/subtract, or derived from funct
// for R-type; unknown funct codes fall back to add.
module alu_decoder
  import mips_pkg::*;
(
  input  logic [1:0] aluop,
  input  logic [5:0] funct,
  output logic [2:0] alucontrol
);

  always_comb begin
    alucontrol = ALU_ADD;
    case (aluop)
      ALUOP_ADD: alucontrol = ALU_ADD;
      ALUOP_SUB: alucontrol = ALU_SUB;
      ALUOP_FUNCT: begin
        case (funct)
          FN_ADD:  alucontrol = ALU_ADD;
          FN_SUB:  alucontrol = ALU_SUB;
          FN_AND:  alucontrol = ALU_AND;
          FN_OR:   alucontrol = ALU_OR;
          FN_SLT:  alucontrol = ALU_SLT;
          default: alucontrol = ALU_ADD;
        endcase
      end
      default: alucontrol = ALU_ADD;
    endcase
  end

endmodule

// File: rtl/mips_multicycle_controller.sv
// Multicycle MIPS control unit: Moore main FSM, ALU decode, PC enable logic,
// and reset gating that silences every output while reset is high.
module mips_multicycle_controller
  import mips_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] op,
  input  logic [5:0] funct,
  input  logic       zero,
  output logic [2:0] alucontrol,
  output logic       alusrca,
  output logic [1:0] alusrcb,
  output logic [1:0] pcsrc,
  output logic       pcen,
  output logic       iord,
  output logic       irwrite,
  output logic       memwrite,
  output logic       regwrite,
  output logic       regdst,
  output logic       memtoreg,
  output logic       illegal
);

  state_t     state, next;
  logic [1:0] aluop;
  logic [2:0] dec_alucontrol;
  logic       alu_used, pcwrite, branch;
  logic       fsm_alusrca, fsm_iord, fsm_irwrite, fsm_memwrite;
  logic       fsm_regwrite, fsm_regdst, fsm_memtoreg, fsm_illegal;
  logic [1:0] fsm_alusrcb, fsm_pcsrc;

  alu_decoder u_alu_decoder (
    .aluop      (aluop),
    .funct      (funct),
    .alucontrol (dec_alucontrol)
  );

  always_ff @(posedge clk) begin
    if (reset) state <= S_FETCH;
    else       state <= next;
  end

  always_comb begin
    next         = S_FETCH;
    aluop        = ALUOP_ADD;
    alu_used     = 1'b0;
    pcwrite      = 1'b0;
    branch       = 1'b0;
    fsm_alusrca  = 1'b0;
    fsm_alusrcb  = 2'b00;
    fsm_pcsrc    = 2'b00;
    fsm_iord     = 1'b0;
    fsm_irwrite  = 1'b0;
    fsm_memwrite = 1'b0;
    fsm_regwrite = 1'b0;
    fsm_regdst   = 1'b0;
    fsm_memtoreg = 1'b0;
    fsm_illegal  = 1'b0;
    case (state)
      S_FETCH: begin
        alu_used    = 1'b1;
        fsm_alusrcb = 2'b01;
        fsm_irwrite = 1'b1;
        pcwrite     = 1'b1;
        next        = S_DECODE;
      end
      S_DECODE: begin
        alu_used    = 1'b1;
        fsm_alusrcb = 2'b11;
        case (op)
          OP_LW, OP_SW: next = S_MEMADR;
          OP_RTYPE:     next = S_RTYPEEX;
          OP_BEQ:       next = S_BEQEX;
          OP_ADDI:      next = S_ADDIEX;
          OP_J:         next = S_JEX;
          default: begin
            fsm_illegal = 1'b1;
            next        = S_FETCH;
          end
        endcase
      end
      S_MEMADR: begin
        alu_used    = 1'b1;
        fsm_alusrca = 1'b1;
        fsm_alusrcb = 2'b10;
        next        = (op == OP_SW) ? S_MEMWR : S_MEMRD;
      end
      S_MEMRD: begin
        fsm_iord = 1'b1;
        next     = S_MEMWB;
      end
      S_MEMWB: begin
        fsm_memtoreg = 1'b1;
        fsm_regwrite = 1'b1;
      end
      S_MEMWR: begin
        fsm_iord     = 1'b1;
        fsm_memwrite = 1'b1;
      end
      S_RTYPEEX: begin
        alu_used    = 1'b1;
        aluop       = ALUOP_FUNCT;
        fsm_alusrca = 1'b1;
        fsm_illegal = !funct_known(funct);
        next        = S_RTYPEWB;
      end
      S_RTYPEWB: begin
        fsm_regdst   = 1'b1;
        fsm_regwrite = 1'b1;
      end
      S_BEQEX: begin
        alu_used    = 1'b1;
        aluop       = ALUOP_SUB;
        fsm_alusrca = 1'b1;
        fsm_pcsrc   = 2'b01;
        branch      = 1'b1;
      end
      S_ADDIEX: begin
        alu_used    = 1'b1;
        fsm_alusrca = 1'b1;
        fsm_alusrcb = 2'b10;
        next        = S_ADDIWB;
      end
      S_ADDIWB: begin
        fsm_regwrite = 1'b1;
      end
      S_JEX: begin
        fsm_pcsrc = 2'b10;
        pcwrite   = 1'b1;
      end
      default: next = S_FETCH;
    endcase
  end

  // Reset overrides the state-derived outputs so no write can leak out while
  // the FSM is being forced back to FETCH.
  always_comb begin
    alucontrol = 3'b000;
    alusrca    = 1'b0;
    alusrcb    = 2'b00;
    pcsrc      = 2'b00;
    pcen       = 1'b0;
    iord       = 1'b0;
    irwrite    = 1'b0;
    memwrite   = 1'b0;
    regwrite   = 1'b0;
    regdst     = 1'b0;
    memtoreg   = 1'b0;
    illegal    = 1'b0;
    if (!reset) begin
      alucontrol = alu_used ? dec_alucontrol : 3'b000;
      alusrca    = fsm_alusrca;
      alusrcb    = fsm_alusrcb;
      pcsrc      = fsm_pcsrc;
      pcen       = pcwrite | (branch & zero);
      iord       = fsm_iord;
      irwrite    = fsm_irwrite;
      memwrite   = fsm_memwrite;
      regwrite   = fsm_regwrite;
      regdst     = fsm_regdst;
      memtoreg   = fsm_memtoreg;
      illegal    = fsm_illegal;
    end
  end

endmodule
